compn_initiator: RTL and testbench
==================================

Name: compn_initiator

Overview:
- Requester side of the comparator-unit handshake (`data_in` / `enable` / `done` / `ab_out`).
- Accepts operand pairs from the ALU sequencer on a valid/ready interface and drives the operand bus and `enable` level.
- Waits for the unit's `done` to rise and then fall, captures the unit's result, and returns it on a valid/ready result interface.
- A timeout guards against a dead or stuck functional unit.

Parameters:
- `inputsize`, 4, width of each operand (A, B); the operand bus is 2*`inputsize`.
- `RES_W`, 4, width of the result returned by the unit.
- `SETUP_CYC`, 1, cycles `data_in` is held stable before `enable` rises (≥1).
- `SYNC_STAGES`, 2, flops synchronizing the incoming `done` (≥2).
- `TIMEOUT_CYC`, 64, maximum cycles spent in ASSERT or RELEASE before abort (≥4).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  operand request valid.
- `req_ready`  out  1  request accepted when `req_valid` && `req_ready` at a clock edge.
- `req_a`  in  `inputsize`  operand A.
- `req_b`  in  `inputsize`  operand B.
- `data_in`  out  2*`inputsize`  operand bus to the unit, {A,B}, A in the upper half.
- `enable`  out  1  registered enable level to the unit.
- `done`  in  1  unit completion level; asynchronous to `clk`.
- `ab_out`  in  `RES_W`  unit result; valid while `done` is high.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_data`  out  `RES_W`  captured result.
- `res_err`  out  1  result slot carries a timeout abort, not data.

Behaviour:
- **Reset (async, `rst_n`=0):**
  - state IDLE.
  - `data_in`=0, `enable`=0, `res_valid`=0, `res_data`=0, `res_err`=0.
  - sync flops=0, timeout counter=0.
  - Reset mid-operation drops `enable` immediately and discards any in-flight result.
- **`done_s`:** output of the `SYNC_STAGES`-deep synchronizer on `done`. Only `done_s` is used by the FSM. `ab_out` is sampled unsynchronized at the capture edge; it is stable by then.
- **`req_ready`:** combinational, = (state==IDLE) && !`done_s`. A stale high `done` blocks new requests.
- **IDLE:** on an accepted request:
  - `data_in` <= {`req_a`,`req_b`}.
  - setup counter <= `SETUP_CYC`.
  - go to SETUP.
- **SETUP:** `enable`=0 and `data_in` held. The counter decrements each edge. At the edge where the counter==1: `enable` <= 1, timeout counter <= 0, go to ASSERT.
- **ASSERT:**
  - `enable`=1 and `data_in` held.
  - At the first edge with `done_s`==1: `res_data` <= `ab_out`, `res_err` <= 0, `enable` <= 0, timeout counter <= 0, go to RELEASE.
  - Otherwise the timeout counter increments.
- **RELEASE:**
  - `enable`=0.
  - At the first edge with `done_s`==0: `res_valid` <= 1, go to RESP.
  - Otherwise the timeout counter increments.
- **Timeout:** if the counter reaches `TIMEOUT_CYC`-1 in ASSERT or RELEASE without its exit condition:
  - `enable` <= 0, `res_data` <= 0, `res_err` <= 1, `res_valid` <= 1, go to RESP.
  - A timeout in RELEASE overrides data already captured in ASSERT.
- **RESP:**
  - `res_valid`, `res_data` and `res_err` are held stable until `res_valid` && `res_ready` at an edge; then `res_valid` <= 0 and go to IDLE.
  - `data_in` keeps its last value until the next accept.
- **Back-to-back requests:** no new request is accepted before the result is consumed; one operation in flight maximum.
- **`res_ready` tied high:** at most 1 cycle is spent in RESP.
- **Latency:** with defaults and a responder that registers `done` one edge after seeing an `enable` change:
  - accept edge E0, `enable` high after E1.
  - `done` high E2, capture and `enable` low at E5.
  - `done` low E6, `res_valid` high after E9.
- **Protocol guarantees:**
  - `enable` never rises unless `done_s`==0.
  - `data_in` never changes while `enable`==1 or in SETUP.
  - `enable` is glitch-free (registered).

Test Plan:
- Basic compare: A=9, B=3, responder returns `ab_out`=1 → `data_in`=8'h93, `enable` high 1 cycle after accept, `res_valid` after E9, `res_data`=1, `res_err`=0.
- Second op with `res_ready` low for 5 cycles: A=2, B=7 → result held 5 cycles, `res_data`=0; `req_ready`=0 throughout; IDLE and `req_ready`=1 on the consume edge.
- Dead unit: `done` held 0 → `enable` drops after `TIMEOUT_CYC`-1=63 cycles in ASSERT, `res_err`=1, `res_data`=0.
- Stuck `done`: `done` never falls after the result → timeout in RELEASE, `res_err`=1; while `done` stays high after consume, `req_ready`=0.
- Reset mid-ASSERT: `rst_n` low while `enable`=1 → `enable`, `res_valid` and `data_in` go 0 asynchronously; after release a new request A=15, B=0 completes normally with `res_data`=1.
- `SETUP_CYC`=3 build: `data_in` stable 3 cycles before the `enable` rise; assertion: `data_in` never changes while `enable`=1.

Source files
------------

// File: rtl/compn_initiator.sv
`default_nettype none
// compn_initiator: requester side of the comparator-unit enable/done handshake.
// Operand pairs in on valid/ready; captured result or timeout abort out on valid/ready.
module compn_initiator #(
  parameter int inputsize   = 4,
  parameter int RES_W       = 4,
  parameter int SETUP_CYC   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [inputsize-1:0]   req_a,
  input  logic [inputsize-1:0]   req_b,
  output logic [2*inputsize-1:0] data_in,
  output logic                   enable,
  input  logic                   done,
  input  logic [RES_W-1:0]       ab_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [RES_W-1:0]       res_data,
  output logic                   res_err
);

  localparam int SW = $clog2(SETUP_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [SW-1:0] SETUP_INIT = SW'(SETUP_CYC);
  localparam logic [SW-1:0] SETUP_ONE  = SW'(1);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1);
  // Abort fires on the edge where the count would reach TIMEOUT_CYC-1.
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ASSERT  = 3'd2,
    S_RELEASE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t                   state_q;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic [SW-1:0]            setup_q;
  logic [TW-1:0]            tmo_q;
  logic [2*inputsize-1:0]   data_in_q;
  logic                     enable_q;
  logic                     res_valid_q;
  logic [RES_W-1:0]         res_data_q;
  logic                     res_err_q;

  logic done_s;
  logic tmo_hit;

  assign done_s    = sync_q[SYNC_STAGES-1];
  assign tmo_hit   = (tmo_q == TMO_LAST);
  assign req_ready = (state_q == S_IDLE) && !done_s;

  assign data_in   = data_in_q;
  assign enable    = enable_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      setup_q     <= '0;
      tmo_q       <= '0;
      data_in_q   <= '0;
      enable_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], done};
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            data_in_q <= {req_a, req_b};
            setup_q   <= SETUP_INIT;
            state_q   <= S_SETUP;
          end
        end
        S_SETUP: begin
          // Hold at the last setup cycle until a stale done has cleared.
          if (setup_q == SETUP_ONE) begin
            if (!done_s) begin
              enable_q <= 1'b1;
              tmo_q    <= '0;
              state_q  <= S_ASSERT;
            end
          end else begin
            setup_q <= setup_q - SETUP_ONE;
          end
        end
        S_ASSERT: begin
          if (done_s) begin
            res_data_q <= ab_out;
            res_err_q  <= 1'b0;
            enable_q   <= 1'b0;
            tmo_q      <= '0;
            state_q    <= S_RELEASE;
          end else if (tmo_hit) begin
            enable_q    <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end
        S_RELEASE: begin
          if (!done_s) begin
            res_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (tmo_hit) begin
            enable_q    <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_compn_initiator.sv
`default_nettype none
// Bench for compn_initiator: vector table, directed corner sequences and randomized
// operations checked against a behavioural model of the comparator handshake.
module tb_compn_initiator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_a = '0, req_b = '0;
  logic [7:0] data_in;
  logic       enable;
  logic       done;
  logic [3:0] ab_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic       res_err;

  logic       req_valid3 = 1'b0;
  logic       req_ready3;
  logic [3:0] req_a3 = '0, req_b3 = '0;
  logic [7:0] data_in3;
  logic       enable3;
  logic       done3;
  logic [3:0] ab_out3;
  logic       res_valid3;
  logic       res_ready3 = 1'b1;
  logic [3:0] res_data3;
  logic       res_err3;

  int nvec = 0;
  int nmis = 0;
  int mode = 0;  // responder: 0 normal, 1 dead, 2 done stuck high

  always #5 clk = ~clk;

  compn_initiator dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .data_in(data_in), .enable(enable),
    .done(done), .ab_out(ab_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err)
  );

  compn_initiator #(.SETUP_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .data_in(data_in3), .enable(enable3),
    .done(done3), .ab_out(ab_out3), .res_valid(res_valid3), .res_ready(res_ready3),
    .res_data(res_data3), .res_err(res_err3)
  );

  // The functional unit being modelled: a magnitude comparator.
  function automatic logic [3:0] cmp_ref(input logic [3:0] a, input logic [3:0] b);
    if (a > b) return 4'd1;
    else if (a < b) return 4'd0;
    else return 4'd2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else if (mode == 1) done <= 1'b0;
    else if (mode == 2) done <= done | enable;
    else done <= enable;
  end
  assign ab_out = done ? cmp_ref(data_in[7:4], data_in[3:0]) : 4'hF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) done3 <= 1'b0;
    else done3 <= enable3;
  end
  assign ab_out3 = done3 ? cmp_ref(data_in3[7:4], data_in3[3:0]) : 4'hF;

  logic [7:0] prev_d = '0, prev_d3 = '0;
  logic       prev_en = 1'b0, prev_en3 = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_en && enable) begin
      nvec++;
      if (data_in !== prev_d) begin
        nmis++;
        $display("FAIL data_in_stable: got %h required %h", data_in, prev_d);
      end
    end
    if (rst_n && prev_en3 && enable3) begin
      nvec++;
      if (data_in3 !== prev_d3) begin
        nmis++;
        $display("FAIL data_in3_stable: got %h required %h", data_in3, prev_d3);
      end
    end
    prev_d   <= data_in;
    prev_en  <= enable;
    prev_d3  <= data_in3;
    prev_en3 <= enable3;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int dly,
                        input logic [3:0] exp_d, input logic exp_e);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    chk("op_req_ready", req_ready, 1);
    req_a = a; req_b = b; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("op_data_in", data_in, {a, b});
    chk("op_busy", req_ready, 0);
    n = 0;
    while (!res_valid && n < 200) begin tick(); n++; end
    chk("op_res_valid", res_valid, 1);
    chk("op_res_data", res_data, exp_d);
    chk("op_res_err", res_err, exp_e);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, exp_d);
      chk("hold_err", res_err, exp_e);
      chk("hold_req_ready", req_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("op_consumed", res_valid, 0);
    chk("op_idle_ready", req_ready, 1);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         m;
    int         dly;
    logic [3:0] exp_d;
    logic       exp_e;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int n;
    logic [3:0] ra, rb;
    logic dead;

    tbl[0] = '{4'd9,  4'd3,  0, 0, 4'd1, 1'b0};
    tbl[1] = '{4'd2,  4'd7,  0, 5, 4'd0, 1'b0};
    tbl[2] = '{4'd4,  4'd4,  0, 1, 4'd2, 1'b0};
    tbl[3] = '{4'd5,  4'd6,  1, 2, 4'd0, 1'b1};
    tbl[4] = '{4'd15, 4'd0,  0, 0, 4'd1, 1'b0};
    tbl[5] = '{4'd0,  4'd15, 0, 3, 4'd0, 1'b0};

    repeat (2) tick();
    chk("rst_enable", enable, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;
    tick();

    // Three-cycle setup build: operands stable for three edges before enable.
    req_a3 = 4'd10; req_b3 = 4'd12; req_valid3 = 1'b1;
    tick();
    req_valid3 = 1'b0;
    n = 0;
    while (!enable3 && n < 20) begin
      chk("setup3_data", data_in3, 8'hAC);
      tick(); n++;
    end
    chk("setup3_cycles", n, 3);
    n = 0;
    while (!res_valid3 && n < 50) begin tick(); n++; end
    chk("setup3_valid", res_valid3, 1);
    chk("setup3_data_out", res_data3, 0);
    chk("setup3_err", res_err3, 0);
    tick();
    chk("setup3_consumed", res_valid3, 0);

    // Latency with res_ready held high.
    res_ready = 1'b1;
    req_a = 4'd9; req_b = 4'd3; req_valid = 1'b1;
    chk("lat_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("lat_e0_en", enable, 0);
    chk("lat_e0_data", data_in, 8'h93);
    tick();
    chk("lat_e1_en", enable, 1);
    repeat (3) tick();
    chk("lat_e4_en", enable, 1);
    tick();
    chk("lat_e5_en", enable, 0);
    chk("lat_e5_data", res_data, 1);
    repeat (3) tick();
    chk("lat_e8_valid", res_valid, 0);
    tick();
    chk("lat_e9_valid", res_valid, 1);
    chk("lat_e9_data", res_data, 1);
    chk("lat_e9_err", res_err, 0);
    tick();
    chk("lat_e10_valid", res_valid, 0);
    chk("lat_e10_ready", req_ready, 1);
    res_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].m;
      run_op(tbl[i].a, tbl[i].b, tbl[i].dly, tbl[i].exp_d, tbl[i].exp_e);
    end
    mode = 0;

    // Dead unit: count cycles enable stays high before the abort.
    mode = 1;
    req_a = 4'd1; req_b = 4'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("dead_en_up", enable, 1);
    n = 0;
    while (enable && n < 200) begin tick(); n++; end
    chk("dead_en_cycles", n, 63);
    chk("dead_valid", res_valid, 1);
    chk("dead_err", res_err, 1);
    chk("dead_data", res_data, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    mode = 0;

    // Stuck done: abort from RELEASE, and a high done blocks new requests.
    mode = 2;
    req_a = 4'd3; req_b = 4'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 200) begin tick(); n++; end
    chk("stuck_valid", res_valid, 1);
    chk("stuck_err", res_err, 1);
    chk("stuck_data", res_data, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stuck_blocked", req_ready, 0);
      tick();
    end
    mode = 0;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    chk("stuck_recovered", req_ready, 1);

    // Reset in the middle of ASSERT.
    req_a = 4'd6; req_b = 4'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rstmid_en_up", enable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_enable", enable, 0);
    chk("rstmid_data_in", data_in, 0);
    chk("rstmid_valid", res_valid, 0);
    tick();
    rst_n = 1'b1;
    run_op(4'd15, 4'd0, 0, 4'd1, 1'b0);

    // Randomized operations against the reference expectation.
    for (int k = 0; k < 24; k++) begin
      ra   = 4'($urandom_range(0, 15));
      rb   = 4'($urandom_range(0, 15));
      dead = ($urandom_range(0, 4) == 0);
      mode = dead ? 1 : 0;
      run_op(ra, rb, int'($urandom_range(0, 3)), dead ? 4'd0 : cmp_ref(ra, rb), dead);
    end
    mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
